pipelined_chunked_addsub: RTL



---
 rtl/pipelined_chunked_addsub_if.sv | 49 ++++
 rtl/pipelined_chunked_addsub.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/pipelined_chunked_addsub_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pipelined_chunked_addsub_if
// Brief    : Issue-side and result-side handshake bundle for the chunked
//            add/sub pipeline. Carries the sat request when
//            CHUNKED_ADDSUB_SAT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface pipelined_chunked_addsub_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_sub;
    logic [TAG_W-1:0] in_tag;
`ifdef CHUNKED_ADDSUB_SAT_EN
    logic             sat;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_res;
    logic             out_cout;
    logic             out_ovf;
    logic             out_zero;
    logic [TAG_W-1:0] out_tag;

    // Issue stage / result consumer side
    modport master (
`ifdef CHUNKED_ADDSUB_SAT_EN
        output sat,
`endif
        output in_valid, in_a, in_b, in_sub, in_tag, out_ready,
        input  in_ready, out_valid, out_res, out_cout, out_ovf, out_zero, out_tag
    );

    // Arithmetic unit side
    modport slave (
`ifdef CHUNKED_ADDSUB_SAT_EN
        input  sat,
`endif
        input  in_valid, in_a, in_b, in_sub, in_tag, out_ready,
        output in_ready, out_valid, out_res, out_cout, out_ovf, out_zero, out_tag
    );
endinterface
`default_nettype wire

// File: rtl/pipelined_chunked_addsub.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pipelined_chunked_addsub
// Brief    : Pipelined carry-select add/subtract, one WIDTH/CHUNKS-bit chunk
//            per stage, global stall on result backpressure.
//            Option: CHUNKED_ADDSUB_SAT_EN adds signed saturation (bus.sat).
// Revision : 1.0 - initial release
// ============================================================================
module pipelined_chunked_addsub #(
    parameter int WIDTH  = 32,
    parameter int CHUNKS = 4,
    parameter int TAG_W  = 4
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    pipelined_chunked_addsub_if.slave bus
);

    localparam int c_cw   = WIDTH / CHUNKS;
    localparam int c_last = CHUNKS - 1;

    if (WIDTH % CHUNKS != 0) begin : g_bad_split
        $error("pipelined_chunked_addsub: WIDTH must be a multiple of CHUNKS");
    end

    // Stage registers; index k holds the operation after chunk k is resolved
    logic [CHUNKS-1:0]            r_val;
    logic [CHUNKS-1:0]            r_sub;
    logic [CHUNKS-1:0]            r_carry;
    logic [CHUNKS-1:0][WIDTH-1:0] r_a;
    logic [CHUNKS-1:0][WIDTH-1:0] r_b;
    logic [CHUNKS-1:0][WIDTH-1:0] r_res;
    logic [CHUNKS-1:0][TAG_W-1:0] r_tag;
    logic                         r_cout;
    logic                         r_ovf;
    logic                         r_zero;

    // Values presented to each stage (input bus for stage 0)
    logic [CHUNKS-1:0]            w_sval;
    logic [CHUNKS-1:0]            w_ssub;
    logic [CHUNKS-1:0]            w_scin;
    logic [CHUNKS-1:0][WIDTH-1:0] w_sa;
    logic [CHUNKS-1:0][WIDTH-1:0] w_sb;
    logic [CHUNKS-1:0][WIDTH-1:0] w_sres;
    logic [CHUNKS-1:0][TAG_W-1:0] w_stag;
    logic [CHUNKS-1:0][WIDTH-1:0] w_nres;
    logic [CHUNKS-1:0]            w_ncarry;

    logic             w_advance;
    logic             w_msb_cin;
    logic             w_ovf;
    logic             w_cout;
    logic             w_zero;
    logic [WIDTH-1:0] w_fres;
    logic             w_unused_last;

`ifdef CHUNKED_ADDSUB_SAT_EN
    localparam logic [WIDTH-1:0] c_smax = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] c_smin = {1'b1, {(WIDTH-1){1'b0}}};
    logic [CHUNKS-1:0] r_sat;
    logic [CHUNKS-1:0] w_ssat;
`endif

    assign w_advance    = ~r_val[c_last] | bus.out_ready;
    assign bus.in_ready = w_advance;

    for (genvar k = 0; k < CHUNKS; k++) begin : g_stage
        if (k == 0) begin : g_entry
            // Subtraction enters as A + ~B with carry-in 1
            assign w_sval[k] = bus.in_valid;
            assign w_ssub[k] = bus.in_sub;
            assign w_scin[k] = bus.in_sub;
            assign w_sa[k]   = bus.in_a;
            assign w_sb[k]   = bus.in_sub ? ~bus.in_b : bus.in_b;
            assign w_sres[k] = '0;
            assign w_stag[k] = bus.in_tag;
`ifdef CHUNKED_ADDSUB_SAT_EN
            assign w_ssat[k] = bus.sat;
`endif
        end else begin : g_chain
            assign w_sval[k] = r_val[k-1];
            assign w_ssub[k] = r_sub[k-1];
            assign w_scin[k] = r_carry[k-1];
            assign w_sa[k]   = r_a[k-1];
            assign w_sb[k]   = r_b[k-1];
            assign w_sres[k] = r_res[k-1];
            assign w_stag[k] = r_tag[k-1];
`ifdef CHUNKED_ADDSUB_SAT_EN
            assign w_ssat[k] = r_sat[k-1];
`endif
        end

        logic [c_cw:0]    w_sum0;
        logic [c_cw:0]    w_sum1;
        logic [c_cw:0]    w_sel;
        logic [WIDTH-1:0] w_merged;

        // Both carry-in cases are formed up front; the registered carry only picks one
        assign w_sum0 = {1'b0, w_sa[k][k*c_cw +: c_cw]} + {1'b0, w_sb[k][k*c_cw +: c_cw]};
        assign w_sum1 = {1'b0, w_sa[k][k*c_cw +: c_cw]} + {1'b0, w_sb[k][k*c_cw +: c_cw]}
                      + {{c_cw{1'b0}}, 1'b1};
        assign w_sel  = w_scin[k] ? w_sum1 : w_sum0;

        always_comb begin
            w_merged                    = w_sres[k];
            w_merged[k*c_cw +: c_cw]    = w_sel[c_cw-1:0];
        end

        assign w_nres[k]   = w_merged;
        assign w_ncarry[k] = w_sel[c_cw];
    end

    // Carry into the MSB is recovered from the MSB sum bit of the last chunk
    assign w_msb_cin = w_sa[c_last][WIDTH-1] ^ w_sb[c_last][WIDTH-1] ^ w_nres[c_last][WIDTH-1];
    assign w_ovf     = w_msb_cin ^ w_ncarry[c_last];
    assign w_cout    = w_ncarry[c_last] ^ w_ssub[c_last];

`ifdef CHUNKED_ADDSUB_SAT_EN
    // A negative wrapped result means the true result overflowed positive
    assign w_fres = (w_ssat[c_last] && w_ovf) ? (w_nres[c_last][WIDTH-1] ? c_smax : c_smin)
                                              : w_nres[c_last];
    assign w_unused_last = ^{r_a[c_last], r_b[c_last], r_carry[c_last], r_sub[c_last], r_sat[c_last]};
`else
    assign w_fres = w_nres[c_last];
    assign w_unused_last = ^{r_a[c_last], r_b[c_last], r_carry[c_last], r_sub[c_last]};
`endif

    assign w_zero = (w_fres == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_val   <= '0;
            r_sub   <= '0;
            r_carry <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_tag   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
`ifdef CHUNKED_ADDSUB_SAT_EN
            r_sat   <= '0;
`endif
        end else if (w_advance) begin
            r_val   <= w_sval;
            r_sub   <= w_ssub;
            r_carry <= w_ncarry;
            r_a     <= w_sa;
            r_b     <= w_sb;
            r_tag   <= w_stag;
            for (int k = 0; k < CHUNKS; k++) begin
                r_res[k] <= (k == c_last) ? w_fres : w_nres[k];
            end
            r_cout  <= w_cout;
            r_ovf   <= w_ovf;
            r_zero  <= w_zero;
`ifdef CHUNKED_ADDSUB_SAT_EN
            r_sat   <= w_ssat;
`endif
        end
    end

    assign bus.out_valid = r_val[c_last];
    assign bus.out_res   = r_res[c_last];
    assign bus.out_cout  = r_cout;
    assign bus.out_ovf   = r_ovf;
    assign bus.out_zero  = r_zero;
    assign bus.out_tag   = r_tag[c_last];

endmodule
`default_nettype wire
